// File: rtl/dense_pkg.sv
// Shared types and arithmetic helper for the parallel int8 dense-layer engine.
package dense_pkg;

    localparam int CFG_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIAS = 3'd1,
        MAC  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } dense_par_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] in_size;
        logic [CFG_W-1:0] out_size;
        logic             relu;
        logic signed [7:0] zp;
    } dense_cfg_t;

    // (x - zp) needs 9 bits; the full product always fits in 17 signed bits.
    function automatic logic signed [16:0] mac_product(
        input logic signed [7:0] x,
        input logic signed [7:0] zp,
        input logic signed [7:0] w
    );
        logic signed [8:0]  diff;
        logic signed [16:0] diff_ext;
        logic signed [16:0] w_ext;
        diff     = {x[7], x} - {zp[7], zp};
        diff_ext = {{8{diff[8]}}, diff};
        w_ext    = {{9{w[7]}}, w};
        return diff_ext * w_ext;
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One output-neuron accumulator: bias preload, then wrapping MAC of (x - zp) * w.
module dense_mac_lane
    import dense_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_bias,
    input  logic                    acc_en,
    input  logic [ACC_W-1:0]        bias,
    input  logic signed [7:0]       x,
    input  logic signed [7:0]       zp,
    input  logic signed [7:0]       w,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [16:0] prod_s;

    // Product of the current operand pair
    always_comb begin
        prod_s = mac_product(x, zp, w);
    end

    // Accumulator: bias load has priority, additions wrap modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= bias;
        end else if (acc_en) begin
            acc <= acc + {{(ACC_W-17){prod_s[16]}}, prod_s};
        end
    end

endmodule

// File: rtl/dense_layer_parallel.sv
// Fully connected int8 layer, LANES neurons per group, results streamed out via valid/ready.
module dense_layer_parallel
    import dense_pkg::*;
#(
    parameter int MAX_IN_SIZE  = 256,
    parameter int MAX_OUT_SIZE = 64,
    parameter int LANES        = 4,
    parameter int ACC_W        = 32
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [$clog2(MAX_IN_SIZE+1)-1:0]                   cfg_in_size,
    input  logic [$clog2(MAX_OUT_SIZE+1)-1:0]                  cfg_out_size,
    input  logic                                               cfg_relu,
    input  logic signed [7:0]                                  cfg_input_zp,
    output logic                                               busy,
    output logic                                               done,
    output logic                                               err_cfg,
    output logic [$clog2(MAX_IN_SIZE)-1:0]                     tensor_ram_addr,
    output logic                                               tensor_ram_re,
    input  logic signed [7:0]                                  tensor_ram_dout,
    output logic [$clog2(MAX_IN_SIZE*MAX_OUT_SIZE/LANES)-1:0]  weight_rom_addr,
    output logic                                               weight_rom_re,
    input  logic [8*LANES-1:0]                                 weight_rom_dout,
    output logic [$clog2(MAX_OUT_SIZE/LANES)-1:0]              bias_rom_addr,
    output logic                                               bias_rom_re,
    input  logic [ACC_W*LANES-1:0]                             bias_rom_dout,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic signed [ACC_W-1:0]                            out_data,
    output logic [$clog2(MAX_OUT_SIZE)-1:0]                    out_idx
);

    localparam int IN_W   = $clog2(MAX_IN_SIZE + 1);
    localparam int OUT_W  = $clog2(MAX_OUT_SIZE + 1);
    localparam int TA_W   = $clog2(MAX_IN_SIZE);
    localparam int WA_W   = $clog2(MAX_IN_SIZE * MAX_OUT_SIZE / LANES);
    localparam int BA_W   = $clog2(MAX_OUT_SIZE / LANES);
    localparam int IDX_W  = $clog2(MAX_OUT_SIZE);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    dense_par_state_t        state_r;
    dense_cfg_t              cfg_r;
    logic                    bphase_r;
    logic [IN_W-1:0]         k_r;
    logic [LANE_W-1:0]       lane_r;
    logic [BA_W-1:0]         g_r;
    logic [WA_W-1:0]         w_ptr_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_cfg_r;
    logic [TA_W-1:0]         tensor_addr_r;
    logic                    tensor_re_r;
    logic [WA_W-1:0]         weight_addr_r;
    logic                    weight_re_r;
    logic [BA_W-1:0]         bias_addr_r;
    logic                    bias_re_r;
    logic                    out_valid_r;
    logic [IDX_W-1:0]        out_idx_r;

    logic                    cfg_ok_s;
    logic                    last_beat_s;
    logic                    group_end_s;
    logic                    load_bias_s;
    logic                    acc_en_s;
    logic signed [ACC_W-1:0] sel_acc_s;
    logic signed [ACC_W-1:0] out_data_s;
    logic signed [ACC_W-1:0] acc_s [LANES];

    // Start-time configuration check
    always_comb begin
        if (cfg_in_size == {IN_W{1'b0}} || cfg_in_size > IN_W'(MAX_IN_SIZE) ||
            cfg_out_size == {OUT_W{1'b0}} || cfg_out_size > OUT_W'(MAX_OUT_SIZE)) begin
            cfg_ok_s = 1'b0;
        end else begin
            cfg_ok_s = 1'b1;
        end
    end

    // Beat bookkeeping: last beat of the layer, and last beat of the current group
    always_comb begin
        if (CFG_W'(out_idx_r) + CFG_W'(1'b1) == cfg_r.out_size) begin
            last_beat_s = 1'b1;
        end else begin
            last_beat_s = 1'b0;
        end
        if (last_beat_s || lane_r == LANE_W'(LANES - 1)) begin
            group_end_s = 1'b1;
        end else begin
            group_end_s = 1'b0;
        end
    end

    // Lane strobes: bias data returns in BIAS cycle 2, MAC data one cycle after issue
    always_comb begin
        load_bias_s = (state_r == BIAS) && bphase_r;
        acc_en_s    = (state_r == MAC) && (k_r != {IN_W{1'b0}});
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            dense_mac_lane #(.ACC_W(ACC_W)) u_lane (
                .clk       (clk),
                .reset     (reset),
                .load_bias (load_bias_s),
                .acc_en    (acc_en_s),
                .bias      (bias_rom_dout[ACC_W*l +: ACC_W]),
                .x         (tensor_ram_dout),
                .zp        (cfg_r.zp),
                .w         (weight_rom_dout[8*l +: 8]),
                .acc       (acc_s[l])
            );
        end
    endgenerate

    // EMIT mux with ReLU; the lane pointer and accumulators hold during stalls
    always_comb begin
        sel_acc_s = acc_s[lane_r];
        if (!out_valid_r) begin
            out_data_s = '0;
        end else if (cfg_r.relu && sel_acc_s[ACC_W-1]) begin
            out_data_s = '0;
        end else begin
            out_data_s = sel_acc_s;
        end
    end

    // Control FSM, address generation and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            cfg_r         <= '0;
            bphase_r      <= 1'b0;
            k_r           <= '0;
            lane_r        <= '0;
            g_r           <= '0;
            w_ptr_r       <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_cfg_r     <= 1'b0;
            tensor_addr_r <= '0;
            tensor_re_r   <= 1'b0;
            weight_addr_r <= '0;
            weight_re_r   <= 1'b0;
            bias_addr_r   <= '0;
            bias_re_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            out_idx_r     <= '0;
        end else begin
            done_r    <= 1'b0;
            err_cfg_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && cfg_ok_s) begin
                        cfg_r.in_size  <= CFG_W'(cfg_in_size);
                        cfg_r.out_size <= CFG_W'(cfg_out_size);
                        cfg_r.relu     <= cfg_relu;
                        cfg_r.zp       <= cfg_input_zp;
                        state_r        <= BIAS;
                        busy_r         <= 1'b1;
                        bphase_r       <= 1'b0;
                        g_r            <= '0;
                        w_ptr_r        <= '0;
                        lane_r         <= '0;
                        out_idx_r      <= '0;
                        bias_re_r      <= 1'b1;
                        bias_addr_r    <= '0;
                    end else if (start) begin
                        err_cfg_r <= 1'b1;
                    end
                end
                BIAS: begin
                    if (!bphase_r) begin
                        bphase_r    <= 1'b1;
                        bias_re_r   <= 1'b0;
                        bias_addr_r <= '0;
                    end else begin
                        bphase_r      <= 1'b0;
                        state_r       <= MAC;
                        k_r           <= '0;
                        tensor_re_r   <= 1'b1;
                        tensor_addr_r <= '0;
                        weight_re_r   <= 1'b1;
                        weight_addr_r <= w_ptr_r;
                    end
                end
                MAC: begin
                    if (CFG_W'(k_r) == cfg_r.in_size) begin
                        // drain cycle: last products were just accumulated
                        state_r     <= EMIT;
                        k_r         <= '0;
                        lane_r      <= '0;
                        out_valid_r <= 1'b1;
                    end else begin
                        k_r     <= k_r + IN_W'(1'b1);
                        w_ptr_r <= w_ptr_r + WA_W'(1'b1);
                        if (CFG_W'(k_r) + CFG_W'(1'b1) < cfg_r.in_size) begin
                            tensor_re_r   <= 1'b1;
                            tensor_addr_r <= TA_W'(k_r + IN_W'(1'b1));
                            weight_re_r   <= 1'b1;
                            weight_addr_r <= w_ptr_r + WA_W'(1'b1);
                        end else begin
                            tensor_re_r   <= 1'b0;
                            tensor_addr_r <= '0;
                            weight_re_r   <= 1'b0;
                            weight_addr_r <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_idx_r <= out_idx_r + IDX_W'(1'b1);
                        if (group_end_s) begin
                            out_valid_r <= 1'b0;
                            lane_r      <= '0;
                            if (last_beat_s) begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r     <= BIAS;
                                bphase_r    <= 1'b0;
                                g_r         <= g_r + BA_W'(1'b1);
                                bias_re_r   <= 1'b1;
                                bias_addr_r <= g_r + BA_W'(1'b1);
                            end
                        end else begin
                            lane_r <= lane_r + LANE_W'(1'b1);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign err_cfg         = err_cfg_r;
    assign tensor_ram_addr = tensor_addr_r;
    assign tensor_ram_re   = tensor_re_r;
    assign weight_rom_addr = weight_addr_r;
    assign weight_rom_re   = weight_re_r;
    assign bias_rom_addr   = bias_addr_r;
    assign bias_rom_re     = bias_re_r;
    assign out_valid       = out_valid_r;
    assign out_data        = out_data_s;
    assign out_idx         = out_idx_r;

endmodule
